pm_port_arbiter: RTL and testbench

Sequencer and arbiter for the single program-memory read port. It shares the port between two requesters: the control unit's instruction fetch and the LPM data path, which reads constants through the Z pointer. It owns the PC/Z address mux, times the fixed memory read latency, and returns each result to the requester that issued it. The block sits between the control unit and program memory, replacing direct PC-to-memory wiring.

---
 rtl/pm_port_arbiter_if.sv | 43 ++++
 rtl/pm_port_arbiter.sv | 137 +++++++++++++
 tb/tb_pm_port_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pm_port_arbiter_if.sv
// Bundle of the program-memory port arbiter's requester and memory-side signals.
// The arbiter connects through the slave modport. The requesters and the memory connect through the master modport.
interface pm_port_arbiter_if;
  // Request/grant: a requester raises i_*_req with a stable i_*_addr and holds both until it sees o_*_gnt.
  // o_*_gnt is combinational and lasts one cycle. The address is consumed in that cycle.
  // Every grant is answered later by exactly one single-cycle o_*_valid pulse. The pulse has no ready and cannot be stalled.
  logic        i_fetch_req;
  logic [15:0] i_fetch_addr;
  logic        o_fetch_gnt;
  logic        o_fetch_valid;
  logic [15:0] o_fetch_data;

  logic        i_lpm_req;
  logic [15:0] i_lpm_addr;
  logic        o_lpm_gnt;
  logic        o_lpm_valid;
  logic [7:0]  o_lpm_data;

  logic        o_pm_en;
  logic [15:0] o_pm_addr;
  logic [15:0] i_pm_data;
  logic        o_busy;

  modport master (
    output i_fetch_req, i_fetch_addr,
    input  o_fetch_gnt, o_fetch_valid, o_fetch_data,
    output i_lpm_req, i_lpm_addr,
    input  o_lpm_gnt, o_lpm_valid, o_lpm_data,
    input  o_pm_en, o_pm_addr,
    output i_pm_data,
    input  o_busy
  );

  modport slave (
    input  i_fetch_req, i_fetch_addr,
    output o_fetch_gnt, o_fetch_valid, o_fetch_data,
    input  i_lpm_req, i_lpm_addr,
    output o_lpm_gnt, o_lpm_valid, o_lpm_data,
    output o_pm_en, o_pm_addr,
    input  i_pm_data,
    output o_busy
  );
endinterface

// File: rtl/pm_port_arbiter.sv
// Shares the single program-memory read port between instruction fetch (PC) and LPM (Z pointer).
// Defining PM_ARB_ROUND_ROBIN_EN turns simultaneous requests into alternating grants instead of fixed fetch priority.
module pm_port_arbiter #(
  parameter int MEM_LAT = 1  // memory read latency in cycles, 1..4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  pm_port_arbiter_if.slave bus,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  state_t      state, state_nx;
  logic [2:0]  lat_cnt, lat_cnt_nx;
  logic        owner_lpm;
  logic        byte_sel;
  logic [15:0] pm_addr;
  logic [15:0] fetch_data;
  logic [7:0]  lpm_data;
  logic        grant_fetch, grant_lpm;
  logic        capture;

`ifdef PM_ARB_ROUND_ROBIN_EN
  logic last_lpm;  // 1 when LPM held the most recent grant

  always_comb begin
    grant_fetch = 1'b0;
    grant_lpm   = 1'b0;
    if (state == ST_IDLE) begin
      if (bus.i_fetch_req && bus.i_lpm_req) begin
        grant_fetch = last_lpm;
        grant_lpm   = !last_lpm;
      end else begin
        grant_fetch = bus.i_fetch_req;
        grant_lpm   = bus.i_lpm_req;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_lpm <= 1'b1;
    end else if (grant_fetch) begin
      last_lpm <= 1'b0;
    end else if (grant_lpm) begin
      last_lpm <= 1'b1;
    end
  end
`else
  always_comb begin
    grant_fetch = 1'b0;
    grant_lpm   = 1'b0;
    if (state == ST_IDLE) begin
      grant_fetch = bus.i_fetch_req;
      grant_lpm   = bus.i_lpm_req && !bus.i_fetch_req;
    end
  end
`endif

  // The cycle with lat_cnt==1 is the one at whose closing edge memory data is valid.
  always_comb begin
    state_nx   = state;
    lat_cnt_nx = lat_cnt;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_fetch || grant_lpm) begin
          state_nx   = ST_WAIT;
          lat_cnt_nx = LAT_INIT;
        end
      end
      ST_WAIT: begin
        lat_cnt_nx = lat_cnt - 3'd1;
        if (lat_cnt == 3'd1) begin
          capture  = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      lat_cnt    <= 3'd0;
      owner_lpm  <= 1'b0;
      byte_sel   <= 1'b0;
      pm_addr    <= 16'd0;
      fetch_data <= 16'd0;
      lpm_data   <= 8'd0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_cnt_nx;
      if (grant_fetch) begin
        owner_lpm <= 1'b0;
        pm_addr   <= bus.i_fetch_addr;
      end else if (grant_lpm) begin
        owner_lpm <= 1'b1;
        byte_sel  <= bus.i_lpm_addr[0];
        pm_addr   <= {1'b0, bus.i_lpm_addr[15:1]};
      end
      // The LPM byte is selected at capture, so o_lpm_data holds only the byte the requester asked for.
      if (capture) begin
        if (owner_lpm) begin
          lpm_data <= byte_sel ? bus.i_pm_data[15:8] : bus.i_pm_data[7:0];
        end else begin
          fetch_data <= bus.i_pm_data;
        end
      end
    end
  end

  assign bus.o_fetch_gnt   = grant_fetch;
  assign bus.o_lpm_gnt     = grant_lpm;
  assign bus.o_fetch_valid = (state == ST_RESP) && !owner_lpm;
  assign bus.o_lpm_valid   = (state == ST_RESP) && owner_lpm;
  assign bus.o_fetch_data  = fetch_data;
  assign bus.o_lpm_data    = lpm_data;
  assign bus.o_pm_en       = (state == ST_WAIT);
  assign bus.o_pm_addr     = pm_addr;
  assign bus.o_busy        = (state != ST_IDLE);
  assign o_dbg_state       = state;

endmodule

// File: tb/tb_pm_port_arbiter.sv
// Self-checking bench for pm_port_arbiter: vector table, corner-case sequences, and a scoreboard on the valid pulses.
module tb_pm_port_arbiter;
  localparam int LAT = 2;

  typedef struct {
    logic        is_lpm;
    logic [15:0] addr;
    logic [15:0] word;
    logic [15:0] exp_pm_addr;
    logic [15:0] exp_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  pm_port_arbiter_if bus();

  pm_port_arbiter #(.MEM_LAT(LAT)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Memory model: the real word appears only in the last enable cycle. Every other cycle carries junk that must be ignored.
  logic [15:0] mem [0:255];
  logic [15:0] junk = 16'h0000;
  int          en_cnt = 0;

  always @(posedge clk) begin
    junk <= 16'($urandom);
    if (bus.o_pm_en) en_cnt <= en_cnt + 1;
    else             en_cnt <= 0;
  end

  assign bus.i_pm_data = (bus.o_pm_en && en_cnt == LAT - 1) ? mem[bus.o_pm_addr[7:0]] : junk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_fetch_q[$];
  logic [7:0]  exp_lpm_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_fetch_valid) begin
      chk("fetch_valid_expected", 16'(exp_fetch_q.size() != 0), 16'd1);
      if (exp_fetch_q.size() != 0) chk("fetch_data", bus.o_fetch_data, exp_fetch_q.pop_front());
    end
    if (bus.o_lpm_valid) begin
      chk("lpm_valid_expected", 16'(exp_lpm_q.size() != 0), 16'd1);
      if (exp_lpm_q.size() != 0) chk("lpm_data", 16'(bus.o_lpm_data), 16'(exp_lpm_q.pop_front()));
    end
    if (bus.o_fetch_gnt || bus.o_lpm_gnt)
      chk("gnt_exclusive", 16'(bus.o_fetch_gnt & bus.o_lpm_gnt), 16'd0);
  end

  task automatic push_exp(input logic is_lpm);
    logic [15:0] pa;
    logic [15:0] w;
    if (is_lpm) begin
      pa = {1'b0, bus.i_lpm_addr[15:1]};
      w  = mem[pa[7:0]];
      exp_lpm_q.push_back(bus.i_lpm_addr[0] ? w[15:8] : w[7:0]);
    end else begin
      exp_fetch_q.push_back(mem[bus.i_fetch_addr[7:0]]);
    end
  endtask

  task automatic run_one(input vec_t v, input string tag);
    int wait_cyc;
    mem[v.exp_pm_addr[7:0]] = v.word;
    @(posedge clk); #1;
    if (v.is_lpm) begin
      bus.i_lpm_req = 1'b1; bus.i_lpm_addr = v.addr;
    end else begin
      bus.i_fetch_req = 1'b1; bus.i_fetch_addr = v.addr;
    end
    @(negedge clk);
    chk({tag, "_gnt"}, 16'(v.is_lpm ? bus.o_lpm_gnt : bus.o_fetch_gnt), 16'd1);
    if (v.is_lpm) exp_lpm_q.push_back(v.exp_data[7:0]);
    else          exp_fetch_q.push_back(v.exp_data);
    @(posedge clk); #1;
    bus.i_fetch_req  = 1'b0;
    bus.i_lpm_req    = 1'b0;
    bus.i_fetch_addr = 16'($urandom);
    bus.i_lpm_addr   = 16'($urandom);
    @(negedge clk);
    chk({tag, "_pm_addr"}, bus.o_pm_addr, v.exp_pm_addr);
    chk({tag, "_pm_en"}, 16'(bus.o_pm_en), 16'd1);
    wait_cyc = 1;
    while (!(v.is_lpm ? bus.o_lpm_valid : bus.o_fetch_valid) && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk({tag, "_latency"}, 16'(wait_cyc), 16'(LAT + 1));
    @(negedge clk);
    chk({tag, "_busy_after"}, 16'(bus.o_busy), 16'd0);
  endtask

  task automatic wait_gnt(output logic got_f, output logic got_l, output int cyc);
    cyc = -1;
    do begin
      @(negedge clk);
      cyc++;
      got_f = bus.o_fetch_gnt;
      got_l = bus.o_lpm_gnt;
    end while (!(got_f || got_l) && cyc < 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[12];
    logic        gf, gl;
    int          cyc;
    int          n;
    logic [3:0]  exp_order;
    logic [15:0] w;
    logic [15:0] a;

    bus.i_fetch_req  = 1'b0;
    bus.i_fetch_addr = 16'h0000;
    bus.i_lpm_req    = 1'b0;
    bus.i_lpm_addr   = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

    vecs[0] = '{1'b0, 16'h0010, 16'hC123, 16'h0010, 16'hC123};
    vecs[1] = '{1'b1, 16'h0021, 16'hBEEF, 16'h0010, 16'h00BE};
    vecs[2] = '{1'b1, 16'h0020, 16'hBEEF, 16'h0010, 16'h00EF};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h9E01, 16'h7FFF, 16'h009E};
    vecs[4] = '{1'b0, 16'hFF42, 16'h0F0F, 16'hFF42, 16'h0F0F};
    vecs[5] = '{1'b1, 16'h0100, 16'h1357, 16'h0080, 16'h0057};
    for (int i = 6; i < 12; i++) begin
      vecs[i].is_lpm = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      w = 16'($urandom);
      vecs[i].addr        = a;
      vecs[i].word        = w;
      vecs[i].exp_pm_addr = vecs[i].is_lpm ? {1'b0, a[15:1]} : a;
      vecs[i].exp_data    = vecs[i].is_lpm ? {8'h00, (a[0] ? w[15:8] : w[7:0])} : w;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 16'(bus.o_busy), 16'd0);
    chk("rst_pm_en", 16'(bus.o_pm_en), 16'd0);
    chk("rst_pm_addr", bus.o_pm_addr, 16'h0000);
    chk("rst_fetch_data", bus.o_fetch_data, 16'h0000);
    chk("rst_lpm_data", 16'(bus.o_lpm_data), 16'h0000);
    chk("rst_valids", 16'({bus.o_fetch_valid, bus.o_lpm_valid}), 16'd0);
    chk("rst_state", 16'(dbg_state), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_one(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held: the tie outcome depends on the arbitration mode
`ifdef PM_ARB_ROUND_ROBIN_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b1000;
`endif
    @(posedge clk); #1;
    bus.i_fetch_req = 1'b1; bus.i_fetch_addr = 16'h0031;
    bus.i_lpm_req   = 1'b1; bus.i_lpm_addr   = 16'h0085;
    for (int g = 0; g < 3; g++) begin
      wait_gnt(gf, gl, cyc);
      chk($sformatf("tie%0d_lpm_gnt", g), 16'(gl), 16'(exp_order[g]));
      chk($sformatf("tie%0d_fetch_gnt", g), 16'(gf), 16'(!exp_order[g]));
      chk($sformatf("tie%0d_cycle", g), 16'(cyc), 16'((g == 0) ? 0 : LAT + 1));
      if (gf || gl) push_exp(gl);
    end
    @(posedge clk); #1;
    bus.i_fetch_req = 1'b0;
    wait_gnt(gf, gl, cyc);
    chk("tie3_lpm_gnt", 16'(gl), 16'(exp_order[3]));
    chk("tie3_cycle", 16'(cyc), 16'(LAT + 1));
    if (gf || gl) push_exp(gl);
    @(posedge clk); #1;
    bus.i_lpm_req = 1'b0;
    repeat (LAT + 3) @(negedge clk);

    // LPM raised while busy, then dropped before any IDLE: it must never be granted
    mem[8'h50] = 16'h1234;
    @(posedge clk); #1;
    bus.i_fetch_req = 1'b1; bus.i_fetch_addr = 16'h0050;
    @(negedge clk);
    chk("drop_fetch_gnt", 16'(bus.o_fetch_gnt), 16'd1);
    exp_fetch_q.push_back(16'h1234);
    @(posedge clk); #1;
    bus.i_fetch_req = 1'b0;
    bus.i_lpm_req   = 1'b1; bus.i_lpm_addr = 16'h0077;
    @(negedge clk);
    n = bus.o_lpm_gnt ? 1 : 0;
    @(posedge clk); #1;
    bus.i_lpm_req = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (bus.o_lpm_gnt) n++;
    end
    chk("drop_lpm_no_gnt", 16'(n), 16'd0);

    // Reset during WAIT aborts the fetch with no valid pulse
    mem[8'h60] = 16'h5A5A;
    @(posedge clk); #1;
    bus.i_fetch_req = 1'b1; bus.i_fetch_addr = 16'h0060;
    @(negedge clk);
    chk("abort_gnt", 16'(bus.o_fetch_gnt), 16'd1);
    @(posedge clk); #1;
    bus.i_fetch_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_wait", 16'(bus.o_pm_en), 16'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 16'(bus.o_busy), 16'd0);
    chk("abort_pm_en", 16'(bus.o_pm_en), 16'd0);
    chk("abort_fetch_data", bus.o_fetch_data, 16'h0000);
    repeat (LAT + 3) @(negedge clk);

    run_one('{1'b0, 16'h0061, 16'hA0B1, 16'h0061, 16'hA0B1}, "post_rst");

    repeat (4) @(negedge clk);
    chk("fetch_q_drained", 16'(exp_fetch_q.size()), 16'd0);
    chk("lpm_q_drained", 16'(exp_lpm_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
